// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side sequencing control: load-use and branch-operand stalls, taken-branch flush, and
// the trap-entry drain/redirect sequence. Optional performance counters under PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic             br_op_D,
    input  logic             branch_taken_D,
    input  logic [4:0]       rd_E,
    input  logic             RegWrite_E,
    input  logic             MemRead_E,
    input  logic [4:0]       rd_M,
    input  logic             RegWrite_M,
    input  logic             MemRead_M,
    input  logic             exception_D,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic [1:0]       pc_sel,
    output logic             trap_busy
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] trap_cnt
`endif
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || CNT_W < 1) begin : g_param_chk
        $error("pipeline_hazard_ctrl: DRAIN_CYCLES must be 1..15 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {StRun, StDrain, StRedirect} state_e;

    localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;

    logic e_match, m_match, ld_use, br_haz;
    logic trap_entry, br_flush;

    always_comb begin
        e_match = (use_rs1_D && (rd_E == rs1_D)) || (use_rs2_D && (rd_E == rs2_D));
        m_match = (use_rs1_D && (rd_M == rs1_D)) || (use_rs2_D && (rd_M == rs2_D));
        ld_use  = MemRead_E && (rd_E != 5'd0) && e_match;
        // ALU results in MEM are forwarded to decode; only a load there still blocks a branch.
        br_haz  = br_op_D && ((RegWrite_E && (rd_E != 5'd0) && e_match) ||
                              (RegWrite_M && MemRead_M && (rd_M != 5'd0) && m_match));
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        pc_sel      = 2'b00;
        trap_busy   = 1'b0;
        trap_entry  = 1'b0;
        br_flush    = 1'b0;
        if (!reset) begin
            case (state_q)
                StRun: begin
                    if (exception_D) begin
                        stall_F     = 1'b1;
                        stall_D     = 1'b1;
                        flush_E     = 1'b1;
                        trap_entry  = 1'b1;
                        drain_cnt_d = DrainLoad;
                        // The entry cycle is itself the first drain cycle.
                        state_d     = (DRAIN_CYCLES <= 1) ? StRedirect : StDrain;
                    end else if (ld_use || br_haz) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end else if (branch_taken_D) begin
                        pc_sel   = 2'b01;
                        flush_D  = 1'b1;
                        br_flush = 1'b1;
                    end
                end
                StDrain: begin
                    stall_F   = 1'b1;
                    stall_D   = 1'b1;
                    flush_E   = 1'b1;
                    trap_busy = 1'b1;
                    if (drain_cnt_q != 4'd0) begin
                        drain_cnt_d = drain_cnt_q - 4'd1;
                    end
                    if (drain_cnt_q <= 4'd1) begin
                        state_d = StRedirect;
                    end
                end
                StRedirect: begin
                    pc_sel    = 2'b10;
                    flush_D   = 1'b1;
                    flush_E   = 1'b1;
                    trap_busy = 1'b1;
                    state_d   = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            drain_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        trap_cnt_d  = trap_cnt_q;
        if ((state_q == StRun) && stall_D) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (br_flush) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (trap_entry) begin
            trap_cnt_d = trap_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            trap_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            trap_cnt_q  <= trap_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign trap_cnt  = trap_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (default DRAIN_CYCLES=2). Expected output vectors
// {stall_F, stall_D, flush_D, flush_E, pc_sel, trap_busy} are queued as stimulus is driven.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 32;

    localparam logic [6:0] ExpNone  = 7'b0000000;
    localparam logic [6:0] ExpStall = 7'b1101000;
    localparam logic [6:0] ExpBr    = 7'b0010010;
    localparam logic [6:0] ExpDrain = 7'b1101001;
    localparam logic [6:0] ExpRedir = 7'b0011101;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_D, rs2_D, rd_E, rd_M;
    logic       use_rs1_D, use_rs2_D, br_op_D, branch_taken_D;
    logic       RegWrite_E, MemRead_E, RegWrite_M, MemRead_M, exception_D;
    logic       stall_F, stall_D, flush_D, flush_E, trap_busy;
    logic [1:0] pc_sel;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, trap_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .rs1_D          (rs1_D),
        .rs2_D          (rs2_D),
        .use_rs1_D      (use_rs1_D),
        .use_rs2_D      (use_rs2_D),
        .br_op_D        (br_op_D),
        .branch_taken_D (branch_taken_D),
        .rd_E           (rd_E),
        .RegWrite_E     (RegWrite_E),
        .MemRead_E      (MemRead_E),
        .rd_M           (rd_M),
        .RegWrite_M     (RegWrite_M),
        .MemRead_M      (MemRead_M),
        .exception_D    (exception_D),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .pc_sel         (pc_sel),
        .trap_busy      (trap_busy)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .trap_cnt       (trap_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic clr();
        reset = 1'b0; rs1_D = '0; rs2_D = '0; rd_E = '0; rd_M = '0;
        use_rs1_D = 1'b0; use_rs2_D = 1'b0; br_op_D = 1'b0; branch_taken_D = 1'b0;
        RegWrite_E = 1'b0; MemRead_E = 1'b0; RegWrite_M = 1'b0; MemRead_M = 1'b0;
        exception_D = 1'b0;
    endtask

    // Inputs are already driven; queue the expectation, compare at negedge, advance one cycle.
    task automatic step(input string tag, input logic [6:0] exp);
        logic [6:0] e;
        string      t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, {25'd0, stall_F, stall_D, flush_D, flush_E, pc_sel, trap_busy}, {25'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use_5();
        MemRead_E = 1'b1; RegWrite_E = 1'b1; rd_E = 5'd5; rs1_D = 5'd5; use_rs1_D = 1'b1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        exception_D = 1'b1;
        set_load_use_5();
        step("reset_forces_zero", ExpNone);
        step("reset_held", ExpNone);

        clr();
        step("idle_after_reset", ExpNone);

        // Load-use: one stall, then load in MEM with no branch -> clear
        clr(); set_load_use_5();
        step("load_use_stall", ExpStall);
        clr(); rd_M = 5'd5; MemRead_M = 1'b1; RegWrite_M = 1'b1; rs1_D = 5'd5; use_rs1_D = 1'b1;
        step("load_use_clears", ExpNone);

        // BEQ on x7 behind ld x7: two stalls, then taken branch honoured
        clr(); br_op_D = 1'b1; branch_taken_D = 1'b1; rs1_D = 5'd7; use_rs1_D = 1'b1;
        rd_E = 5'd7; MemRead_E = 1'b1; RegWrite_E = 1'b1;
        step("br_ld_stall1", ExpStall);
        clr(); br_op_D = 1'b1; branch_taken_D = 1'b1; rs1_D = 5'd7; use_rs1_D = 1'b1;
        rd_M = 5'd7; MemRead_M = 1'b1; RegWrite_M = 1'b1;
        step("br_ld_stall2", ExpStall);
        clr(); br_op_D = 1'b1; branch_taken_D = 1'b1; rs1_D = 5'd7; use_rs1_D = 1'b1;
        step("br_ld_taken", ExpBr);

        // Branch on rs2 behind ALU producer: one stall, ALU result in MEM is no hazard
        clr(); br_op_D = 1'b1; branch_taken_D = 1'b1; rs2_D = 5'd9; use_rs2_D = 1'b1;
        rd_E = 5'd9; RegWrite_E = 1'b1;
        step("br_alu_stall", ExpStall);
        clr(); br_op_D = 1'b1; branch_taken_D = 1'b1; rs2_D = 5'd9; use_rs2_D = 1'b1;
        rd_M = 5'd9; RegWrite_M = 1'b1;
        step("br_alu_taken", ExpBr);

        // x0 producers and unused source fields never stall
        clr(); rd_E = 5'd0; MemRead_E = 1'b1; RegWrite_E = 1'b1; rs1_D = 5'd0; use_rs1_D = 1'b1;
        br_op_D = 1'b1;
        step("x0_no_stall", ExpNone);
        clr(); rd_E = 5'd3; MemRead_E = 1'b1; rs2_D = 5'd3; use_rs2_D = 1'b0;
        step("unused_rs2_no_stall", ExpNone);
        clr(); br_op_D = 1'b1; rs1_D = 5'd4; use_rs1_D = 1'b1; rd_E = 5'd4; RegWrite_E = 1'b0;
        branch_taken_D = 1'b1;
        step("no_regwrite_taken", ExpBr);

        // Trap with load-use in the same cycle: trap wins; second exception ignored
        clr(); exception_D = 1'b1; set_load_use_5(); branch_taken_D = 1'b1;
        step("trap_entry", ExpStall);
        clr(); exception_D = 1'b1; branch_taken_D = 1'b1;
        step("trap_drain", ExpDrain);
        clr(); exception_D = 1'b1;
        step("trap_redirect", ExpRedir);
        clr();
        step("trap_back_to_run", ExpNone);
        clr(); branch_taken_D = 1'b1;
        step("run_branch_after_trap", ExpBr);

        // Reset during DRAIN aborts without redirect
        clr(); exception_D = 1'b1;
        step("trap2_entry", ExpStall);
        clr();
        step("trap2_drain", ExpDrain);
        clr(); reset = 1'b1;
        step("trap2_reset", ExpNone);
        clr();
        step("trap2_no_redirect", ExpNone);
`ifdef PERF_CNT_EN
        check_eq("trap_cnt_cleared", trap_cnt, 32'd0);
`endif
        clr(); set_load_use_5();
        step("run_after_abort", ExpStall);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage RV64 core, sitting beside the decode stage. It produces stall, flush and PC-select controls for three cases: load-use hazards, operand hazards on branches resolved in decode, and the multi-cycle trap-entry sequence started by the decode-stage exception detector. The trap sequence is a registered FSM with a drain counter; hazard and branch decisions are combinational on top of that state.

## Interface
- `DRAIN_CYCLES`, default 2: cycles spent draining older instructions before trap redirect; legal 1..15.
- `CNT_W`, default 32: width of the performance counters (only with `PERF_CNT_EN`).

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rs1_D`, `rs2_D`  in  5 each  source registers of the instruction in decode.
- `use_rs1_D`, `use_rs2_D`  in  1 each  decode instruction actually reads rs1/rs2.
- `br_op_D`  in  1  decode instruction compares/uses operands in decode (BEQ, BNE, JALR).
- `branch_taken_D`  in  1  decode branch/jump redirect (taken BEQ/BNE, JAL, JALR).
- `rd_E`, `RegWrite_E`, `MemRead_E`  in  5/1/1  destination and control of the EX-stage instruction.
- `rd_M`, `RegWrite_M`, `MemRead_M`  in  5/1/1  destination and control of the MEM-stage instruction.
- `exception_D`  in  1  exception flag for the decode instruction.
- `stall_F`, `stall_D`  out  1  hold PC and the IF/ID register.
- `flush_D`  out  1  load a bubble into IF/ID.
- `flush_E`  out  1  load a bubble into ID/EX.
- `pc_sel`  out  2  PC source: 00 = PC+4, 01 = decode branch target, 10 = trap handler, 11 = unused.
- `trap_busy`  out  1  trap sequence in progress.
- `stall_cnt`, `flush_cnt`, `trap_cnt`  out  CNT_W each  counters (`PERF_CNT_EN` only).

## Operation
FSM states:
- RUN: normal operation.
- DRAIN: waiting for older instructions to retire; uses a 4-bit counter.
- REDIRECT: one cycle that steers fetch to the handler.

In RUN, conditions are evaluated in this priority order:
1. Trap entry, when `exception_D`=1.
   - Go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
   - In the entry cycle: `stall_F`=`stall_D`=1, `flush_E`=1.
   - All hazard and branch conditions are ignored in this cycle.
2. Load-use hazard: `MemRead_E` & `rd_E`≠0 & ((`use_rs1_D` & `rd_E`==`rs1_D`) | (`use_rs2_D` & `rd_E`==`rs2_D`)).
3. Branch operand hazard: `br_op_D` & [(`RegWrite_E` & `rd_E`≠0 & match) | (`RegWrite_M` & `MemRead_M` & `rd_M`≠0 & match)]. "Match" means `rd` equals `rs1_D` or `rs2_D`, gated by the matching `use_rs*_D` bit.
   - Cases 2 and 3 produce the same response: `stall_F`=`stall_D`=1, `flush_E`=1, `pc_sel`=00.
   - `branch_taken_D` is ignored while stalled, because its operands are stale.
4. Taken branch, when `branch_taken_D`=1 and there is no stall: `pc_sel`=01, `flush_D`=1.
5. Otherwise all outputs are 0.

Other states:
- DRAIN: `stall_F`=`stall_D`=1, `flush_E`=1, `trap_busy`=1.
  - The counter decrements each cycle.
  - At count 0, go to REDIRECT.
- REDIRECT: `pc_sel`=10, `flush_D`=1, `flush_E`=1, `trap_busy`=1; next state is RUN.
- `exception_D` and `branch_taken_D` are ignored in DRAIN and REDIRECT.
- The WB stage is not checked. The register file writes through, so a same-cycle WB write is visible to decode.

## Timing
- FSM and counters are registered. `stall_*`, `flush_*` and `pc_sel` are combinational from state plus the current-cycle inputs, so the response lands in the same cycle.
- Reset: while `reset`=1, all outputs are forced to 0 and `pc_sel`=00. On the next edge: state=RUN, drain counter=0, counters=0.
- Reset asserted during DRAIN or REDIRECT aborts the sequence; no redirect is issued.
- Trap latency: exception cycle T. Stall outputs are asserted for T..T+DRAIN_CYCLES-1. The handler redirect is at T+DRAIN_CYCLES, and the first handler instruction is fetched at T+DRAIN_CYCLES+1.
- Load-use stall lasts exactly 1 cycle, because the load moves to MEM and the condition clears.
- Branch hazard against an ALU producer in EX: 1 stall cycle. Against a load producer in EX: 2 cycles (load-use, then the M-stage load rule).
- `rd`=x0 never creates a hazard.

## Configuration
- `PERF_CNT_EN` defined:
  - `stall_cnt` increments on each cycle with `stall_D`=1 in RUN.
  - `flush_cnt` increments on each taken-branch flush.
  - `trap_cnt` increments on each DRAIN entry.
  - All counters wrap modulo 2^CNT_W and clear on reset.
- `PERF_CNT_EN` not defined: the counter ports and logic are absent; control behaviour is identical.

## Test plan
- Load-use: `MemRead_E`=1, `rd_E`=5, `rs1_D`=5, `use_rs1_D`=1 → 1 cycle of `stall_F`/`stall_D`/`flush_E`=1, then all 0.
- Branch after load: BEQ using x7, with a `ld` x7 in EX → stalls 2 cycles; the third cycle honours `branch_taken_D`=1 with `pc_sel`=01, `flush_D`=1.
- x0 producer: `rd_E`=0, `MemRead_E`=1, `rs1_D`=0 → no stall.
- Trap with DRAIN_CYCLES=2: `exception_D` at T → stall at T and T+1, `pc_sel`=10 at T+2, RUN at T+3; a second `exception_D` at T+1 is ignored.
- Simultaneous `exception_D` and load-use at T → trap path wins; `trap_busy`=1 at T+1.
- Reset during DRAIN → next cycle is RUN with all outputs 0; with `PERF_CNT_EN`, `trap_cnt`=0.
